instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- Front end of the single-issue MIPS core.
- Owns the PC, issues one-at-a-time requests to instruction memory, and presents each fetched word on Instruction to the controller with a valid/ready handshake.
- Consumes the controller's Branch and ALUZero outputs, produces PCSrc, and redirects fetch on a taken branch, discarding wrong-path words.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- MAX_WAIT, 16, cycles a memory request may stay outstanding before FetchError; range 1..255.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  one clock; reset is synchronous and active-low.
- IMemReq  output  1  request to instruction memory.
- IMemAddr  output  32  word-aligned fetch address.
- IMemValid  input  1  memory response valid.
- IMemData  input  32  memory response word.
- Instruction  output  32  fetched word to controller.
- InstrValid  output  1  Instruction holds a valid word.
- InstrReady  input  1  decode stage accepts Instruction.
- BranchResolve  input  1  branch outcome inputs valid this cycle.
- Branch  input  1  controller Branch.
- ALUZero  input  1  controller ALUZero.
- BranchTarget  input  32  taken-branch target; bits [1:0] ignored and forced to 00.
- PCSrc  output  1  taken-branch select, combinational: BranchResolve & Branch & ALUZero.
- PC  output  32  current fetch PC.
- InstrCount  output  32  count of accepted instructions; wraps at 2^32.
- FetchError  output  1  sticky memory-timeout flag.

Behaviour:
- Reset (Rst=0 at an edge): PC=RESET_PC, IMemAddr=RESET_PC, IMemReq=0, Instruction=0, InstrValid=0, InstrCount=0, FetchError=0, wait counter=0, state=IDLE. Reset overrides every other event, including mid-request or mid-drain.
- States: IDLE, REQ, HOLD, DRAIN, ERROR.
- IDLE: lasts one cycle after reset release, then REQ.
- REQ:
  - IMemReq=1, IMemAddr=PC, both held stable until completion.
  - Completion is an edge with IMemReq=1 and IMemValid=1. On completion: Instruction<=IMemData, InstrValid<=1, PC<=PC+4 (mod 2^32; 0xFFFF_FFFC wraps to 0), go to HOLD.
  - Minimum latency is one cycle: a word with IMemValid high in the first REQ cycle appears on Instruction the following cycle.
- HOLD:
  - IMemReq=0. Instruction and InstrValid stay stable until accepted.
  - Edge with InstrReady=1: InstrCount+1, InstrValid<=0, go to REQ.
- Wait counter:
  - Increments each REQ or DRAIN cycle without IMemValid; clears on completion.
  - Reaching MAX_WAIT: FetchError<=1, IMemReq<=0, go to ERROR.
- ERROR: terminal until reset; all outputs hold except IMemReq=0 and InstrValid=0.
- Redirect (PCSrc=1 at an edge), by state:
  - REQ with IMemValid=1: response discarded, PC<=target, stay in REQ with the new address next cycle.
  - REQ with IMemValid=0: PC<=target, go to DRAIN.
  - DRAIN: IMemReq stays 1 with the old address until IMemValid, which is discarded; then go to REQ at the target. A second PCSrc during DRAIN updates the target only.
  - HOLD: redirect wins over InstrReady in the same cycle. The held word is dropped (InstrValid<=0, not counted), PC<=target, go to REQ.
  - IDLE or ERROR: PCSrc is ignored.
- Discarded words never assert InstrValid and never increment InstrCount.
- Only one request is outstanding at any time.

Test Plan:
- Reset, then memory returns 32'h0000_0000 and 32'h0022_1820 with 1-cycle latency, InstrReady=1 -> IMemAddr steps 0, 4, 8; InstrValid pulses with each word; InstrCount=2.
- InstrReady=0 for 5 cycles while in HOLD with lw word 32'h8C22_0004 -> Instruction/InstrValid stable for 5 cycles, IMemReq=0, PC=4; accepted on the 6th cycle.
- In HOLD, BranchResolve=1, Branch=1, ALUZero=1, BranchTarget=32'h40, InstrReady=1 same cycle -> PCSrc=1, word dropped, InstrCount unchanged, next IMemAddr=32'h40.
- Redirect to 32'h80 while a request to 32'h10 is pending with 3-cycle latency -> DRAIN; old response discarded; IMemAddr=32'h80 next; no InstrValid for the 32'h10 word. Also Branch=1, ALUZero=0 -> PCSrc=0 and no redirect.
- IMemValid held low -> FetchError=1 after 16 REQ cycles; IMemReq=0; stays in ERROR until Rst=0; RESET_PC=32'hFFFF_FFFC fetch wraps the next address to 0.
- Rst=0 asserted mid-DRAIN -> next edge all outputs at reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, issues one instruction-memory request at a time,
// hands each word to decode over a valid/ready handshake and handles branch redirects.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemValid,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        BranchResolve,
  input  logic        Branch,
  input  logic        ALUZero,
  input  logic [31:0] BranchTarget,
  output logic        PCSrc,
  output logic [31:0] PC,
  output logic [31:0] InstrCount,
  output logic        FetchError
);

  // state | meaning
  // IDLE  | one cycle after reset release
  // REQ   | request to IMemAddr (== PC) outstanding
  // HOLD  | word presented on Instruction, waiting for InstrReady
  // DRAIN | wrong-path request outstanding; its response is discarded
  // ERROR | memory timeout, terminal until reset
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN,
    S_ERROR
  } state_t;

  localparam logic [7:0] MaxWaitC = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic        err_q, err_d;
  logic [7:0]  wait_q, wait_d;

  logic [31:0] target;
  logic [7:0]  wait_inc;
  logic        timeout;

  assign PCSrc    = BranchResolve & Branch & ALUZero;
  assign target   = {BranchTarget[31:2], 2'b00};
  assign wait_inc = wait_q + 8'd1;
  assign timeout  = (wait_inc == MaxWaitC);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = valid_q;
    count_d = count_q;
    err_d   = err_q;
    wait_d  = wait_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (IMemValid) begin
          wait_d = 8'd0;
          if (PCSrc) begin
            pc_d = target;
          end else begin
            instr_d = IMemData;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = S_HOLD;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else begin
          wait_d = wait_inc;
          if (PCSrc) begin
            pc_d    = target;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (PCSrc) pc_d = target;
        if (IMemValid) begin
          wait_d  = 8'd0;
          state_d = S_REQ;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_HOLD: begin
        // a redirect drops the held word even if decode accepts it this cycle
        if (PCSrc) begin
          valid_d = 1'b0;
          pc_d    = target;
          state_d = S_REQ;
        end else if (InstrReady) begin
          valid_d = 1'b0;
          count_d = count_q + 32'd1;
          state_d = S_REQ;
        end
      end
      S_ERROR: valid_d = 1'b0;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_REQ) addr_d = pc_d;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
      err_q   <= 1'b0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      count_q <= count_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  assign IMemReq     = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign IMemAddr    = addr_q;
  assign Instruction = instr_q;
  assign InstrValid  = valid_q;
  assign PC          = pc_q;
  assign InstrCount  = count_q;
  assign FetchError  = err_q;

endmodule
